// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a transparent-high latch register file: SETUP -> OPEN (GATE_CYC) -> CLOSE.
// Optional sticky out-of-range address flag is built when LBWC_ADDR_CHECK_EN is defined.
module latch_bank_wr_ctrl #(
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int GATE_CYC = 1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             err_clr,
  output logic [DW-1:0]    lat_d,
  output logic [DEPTH-1:0] lat_g,
  output logic             busy,
  output logic             err
);

  localparam int CW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_OPEN  = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_busy;
  logic [DW-1:0]    r_d;
  logic [DEPTH-1:0] r_g;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_addr;
  logic             r_err;

  logic             w_accept;
  logic             w_addr_ok;
  logic             w_in_addr_ok;
  logic [DEPTH-1:0] w_dec;

  assign w_accept     = wr_valid && r_ready;
  assign w_addr_ok    = {1'b0, r_addr} < DEPTH_W;
  assign w_in_addr_ok = {1'b0, wr_addr} < DEPTH_W;
  assign w_dec        = w_addr_ok ? (DEPTH'(1) << r_addr) : '0;

  // Gate is only ever loaded from the registered decode, so it cannot glitch.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_d     <= '0;
      r_g     <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SETUP;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_d     <= wr_data;
            r_addr  <= wr_addr;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_OPEN;
          r_g     <= w_dec;
          r_cnt   <= CW'(GATE_CYC - 1);
        end
        S_OPEN: begin
          if (r_cnt == '0) begin
            r_state <= S_CLOSE;
            r_g     <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CLOSE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_g     <= '0;
        end
      endcase
    end
  end

`ifdef LBWC_ADDR_CHECK_EN
  // A new violation on the same edge as a clear keeps the flag set.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_in_addr_ok) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_unused = err_clr ^ w_in_addr_ok;
  assign r_err    = 1'b0;
`endif

  assign wr_ready = r_ready;
  assign busy     = r_busy;
  assign lat_d    = r_d;
  assign lat_g    = r_g;
  assign err      = r_err;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Directed bench: three controller instances (GATE_CYC=1, GATE_CYC=3, DEPTH=6).
module tb_latch_bank_wr_ctrl;

  logic CK;
  logic RN;

  logic       v1, c1, r1, b1, e1;
  logic [2:0] a1;
  logic [7:0] d1, ld1, g1;

  logic       v3, c3, r3, b3, e3;
  logic [2:0] a3;
  logic [7:0] d3, ld3, g3;

  logic       v6, c6, r6, b6, e6;
  logic [2:0] a6;
  logic [7:0] d6, ld6;
  logic [5:0] g6;

  int n_chk;
  int n_err;

`ifdef LBWC_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  latch_bank_wr_ctrl #(.DW(8), .DEPTH(8), .AW(3), .GATE_CYC(1)) u_g1 (
    .CK(CK), .RN(RN), .wr_valid(v1), .wr_ready(r1), .wr_addr(a1), .wr_data(d1),
    .err_clr(c1), .lat_d(ld1), .lat_g(g1), .busy(b1), .err(e1));

  latch_bank_wr_ctrl #(.DW(8), .DEPTH(8), .AW(3), .GATE_CYC(3)) u_g3 (
    .CK(CK), .RN(RN), .wr_valid(v3), .wr_ready(r3), .wr_addr(a3), .wr_data(d3),
    .err_clr(c3), .lat_d(ld3), .lat_g(g3), .busy(b3), .err(e3));

  latch_bank_wr_ctrl #(.DW(8), .DEPTH(6), .AW(3), .GATE_CYC(1)) u_d6 (
    .CK(CK), .RN(RN), .wr_valid(v6), .wr_ready(r6), .wr_addr(a6), .wr_data(d6),
    .err_clr(c6), .lat_d(ld6), .lat_g(g6), .busy(b6), .err(e6));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       rdy;
    logic [7:0] ld;
    logic [7:0] g;
    logic       bsy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    n_chk = 0;
    n_err = 0;
    // inputs applied before an edge, expected outputs just after it
    tbl[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 8'hA5, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hA5, 8'h08, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'hA5, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 3'd0, 8'h3C, 1'b0, 8'h3C, 8'h00, 1'b1};
    tbl[5]  = '{1'b1, 3'd7, 8'hC3, 1'b0, 8'h3C, 8'h01, 1'b1};
    tbl[6]  = '{1'b1, 3'd7, 8'hC3, 1'b0, 8'h3C, 8'h00, 1'b1};
    tbl[7]  = '{1'b1, 3'd7, 8'hC3, 1'b1, 8'h3C, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 3'd7, 8'hC3, 1'b0, 8'hC3, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hC3, 8'h80, 1'b1};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hC3, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'hC3, 8'h00, 1'b0};

    RN = 1'b0;
    v1 = 0; a1 = 0; d1 = 0; c1 = 0;
    v3 = 0; a3 = 0; d3 = 0; c3 = 0;
    v6 = 0; a6 = 0; d6 = 0; c6 = 0;

    // reset state
    tick();
    tick();
    chk("rst_ready", 32'(r1), 32'd0);
    chk("rst_lat_d", 32'(ld1), 32'h0);
    chk("rst_lat_g", 32'(g1), 32'h0);
    chk("rst_busy", 32'(b1), 32'd0);
    chk("rst_err", 32'(e6), 32'd0);
    chk("rst_ready_g3", 32'(r3), 32'd0);
    #4 RN = 1'b1;
    tick();
    chk("rel_ready", 32'(r1), 32'd1);
    chk("rel_busy", 32'(b1), 32'd0);

    // GATE_CYC=1 single write then held-valid back-to-back writes
    for (int i = 0; i < 12; i++) begin
      v1 = tbl[i].v;
      a1 = tbl[i].a;
      d1 = tbl[i].d;
      tick();
      chk($sformatf("vec%0d_ready", i), 32'(r1), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_lat_d", i), 32'(ld1), 32'(tbl[i].ld));
      chk($sformatf("vec%0d_lat_g", i), 32'(g1), 32'(tbl[i].g));
      chk($sformatf("vec%0d_busy", i), 32'(b1), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_onehot", i), 32'($countones(g1) <= 1), 32'd1);
    end

    // GATE_CYC=3, addr 5: SETUP, 3x OPEN, CLOSE, IDLE
    v3 = 1; a3 = 3'd5; d3 = 8'h5A;
    tick();
    v3 = 0; a3 = 0; d3 = 8'hFF;
    chk("g3_setup_g", 32'(g3), 32'h0);
    chk("g3_setup_d", 32'(ld3), 32'h5A);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("g3_open%0d_g", k), 32'(g3), 32'h20);
      chk($sformatf("g3_open%0d_d", k), 32'(ld3), 32'h5A);
      chk($sformatf("g3_open%0d_ready", k), 32'(r3), 32'd0);
    end
    tick();
    chk("g3_close_g", 32'(g3), 32'h0);
    chk("g3_close_d", 32'(ld3), 32'h5A);
    chk("g3_close_busy", 32'(b3), 32'd1);
    tick();
    chk("g3_idle_ready", 32'(r3), 32'd1);
    chk("g3_idle_busy", 32'(b3), 32'd0);
    chk("g3_idle_d", 32'(ld3), 32'h5A);

    // async reset during OPEN
    v1 = 1; a1 = 3'd2; d1 = 8'h11;
    tick();
    v1 = 0;
    tick();
    chk("ar_open_g", 32'(g1), 32'h04);
    #3 RN = 1'b0;
    #1;
    chk("ar_g_async", 32'(g1), 32'h0);
    chk("ar_busy_async", 32'(b1), 32'd0);
    chk("ar_ready_async", 32'(r1), 32'd0);
    #2 RN = 1'b1;
    tick();
    chk("ar_rel_ready", 32'(r1), 32'd1);
    v1 = 1; a1 = 3'd6; d1 = 8'h66;
    tick();
    v1 = 0;
    chk("ar_w_setup_d", 32'(ld1), 32'h66);
    chk("ar_w_setup_g", 32'(g1), 32'h0);
    tick();
    chk("ar_w_open_g", 32'(g1), 32'h40);
    tick();
    chk("ar_w_close_g", 32'(g1), 32'h0);
    tick();
    chk("ar_w_idle_ready", 32'(r1), 32'd1);

    // DEPTH=6, out-of-range addr 7
    chk("d6_ready", 32'(r6), 32'd1);
    v6 = 1; a6 = 3'd7; d6 = 8'h77;
    tick();
    v6 = 0;
    chk("d6_setup_err", 32'(e6), 32'(ADDR_CHK));
    chk("d6_setup_busy", 32'(b6), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("d6_cyc%0d_g", k), 32'(g6), 32'h0);
      chk($sformatf("d6_cyc%0d_err", k), 32'(e6), 32'(ADDR_CHK));
    end
    chk("d6_back_ready", 32'(r6), 32'd1);
    c6 = 1;
    tick();
    c6 = 0;
    chk("d6_clr_err", 32'(e6), 32'd0);
    // set and clear on the same edge: set wins
    v6 = 1; a6 = 3'd6; c6 = 1;
    tick();
    v6 = 0; c6 = 0;
    chk("d6_setwins_err", 32'(e6), 32'(ADDR_CHK));
    tick();
    chk("d6_setwins_g", 32'(g6), 32'h0);
    tick();
    tick();
    chk("d6_ready_again", 32'(r6), 32'd1);
    // in-range write on the DEPTH=6 instance still opens its gate
    v6 = 1; a6 = 3'd5; d6 = 8'h55;
    tick();
    v6 = 0;
    tick();
    chk("d6_inrange_g", 32'(g6), 32'h20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
